// File: rtl/tail_light_pkg.sv
// Shared lamp pattern constants, side FSM states and error codes for the tail-light monitor.
package tail_light_pkg;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_S1  = 3'b001;
  localparam logic [2:0] LAMP_S2  = 3'b011;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEADY,
    ST_SEQ_A,
    ST_SEQ_B,
    ST_SEQ_C
  } side_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PATTERN = 2'd1,
    ERR_TRANS   = 2'd2,
    ERR_DUAL    = 2'd3
  } err_code_t;

  function automatic logic lamp_legal(input logic [2:0] p);
    return (p == LAMP_OFF) || (p == LAMP_S1) || (p == LAMP_S2) || (p == LAMP_ALL);
  endfunction

  // An illegal previous sample was already flagged as a pattern error, so it is
  // not flagged a second time as a bad transition.
  function automatic logic succ_legal(input logic [2:0] prev, input logic [2:0] cur);
    case (prev)
      LAMP_OFF: return (cur == LAMP_OFF) || (cur == LAMP_S1) || (cur == LAMP_ALL);
      LAMP_S1:  return (cur == LAMP_S2) || (cur == LAMP_OFF) || (cur == LAMP_ALL);
      LAMP_S2:  return (cur == LAMP_ALL) || (cur == LAMP_OFF);
      LAMP_ALL: return (cur == LAMP_ALL) || (cur == LAMP_OFF);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_side_decoder.sv
// One-side lamp decoder: previous sample, sweep/steady FSM, and completed-sweep counter.
//   state     | meaning
//   ST_IDLE   | no sweep in progress, not steady
//   ST_STEADY | 111 seen on two consecutive samples (brake)
//   ST_SEQ_A  | saw 001
//   ST_SEQ_B  | saw 011 after 001
//   ST_SEQ_C  | saw 111 after 011; a following 000 completes the sweep
module tail_light_side_decoder
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       lamp,
  input  logic             seq_kill,
  output logic             seq_active,
  output logic             seq_active_nxt,
  output logic             steady_on,
  output logic             pat_err,
  output logic             trans_err,
  output logic [CNT_W-1:0] seq_cnt
);

  logic [2:0]  prev;
  side_state_t state;
  logic        side_err;
  logic        seq_set;
  logic        seq_clr;
  logic        sweep_done;

  always_comb begin
    pat_err        = !lamp_legal(lamp);
    trans_err      = !pat_err && !succ_legal(prev, lamp);
    side_err       = pat_err || trans_err;
    seq_set        = !side_err && (prev == LAMP_S1) && (lamp == LAMP_S2);
    // The single 000 between back-to-back sweeps must not drop seq_active.
    seq_clr        = side_err || ((prev == LAMP_OFF) && (lamp == LAMP_OFF))
                              || ((prev == LAMP_ALL) && (lamp == LAMP_ALL));
    seq_active_nxt = seq_set || (seq_active && !seq_clr);
    sweep_done     = !side_err && (state == ST_SEQ_C) && (lamp == LAMP_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= LAMP_OFF;
      state      <= ST_IDLE;
      steady_on  <= 1'b0;
      seq_active <= 1'b0;
      seq_cnt    <= '0;
    end else begin
      prev       <= lamp;
      seq_active <= seq_active_nxt && !seq_kill;
      state      <= ST_IDLE;
      steady_on  <= 1'b0;
      if (sweep_done)
        seq_cnt <= seq_cnt + 1'b1;
      if (!side_err) begin
        case (lamp)
          LAMP_S1: state <= ST_SEQ_A;
          LAMP_S2: if (state == ST_SEQ_A) state <= ST_SEQ_B;
          LAMP_ALL: begin
            if (state == ST_SEQ_B) begin
              state <= ST_SEQ_C;
            end else if (prev == LAMP_ALL) begin
              state     <= ST_STEADY;
              steady_on <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/tail_light_monitor.sv
// Tail-light lamp bus monitor: brake/turn recovery, sweep counts, sticky error flag.
// Define TAIL_LIGHT_MON_ERR_CODE_EN to add the err_code cause capture output.
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       left_tail_light_controll,
  input  logic [2:0]       right_tail_light_controll,
  input  logic             err_clr,
  output logic             brake_det,
  output logic             turn_left_det,
  output logic             turn_right_det,
  output logic [CNT_W-1:0] left_seq_cnt,
  output logic [CNT_W-1:0] right_seq_cnt,
  output logic             err
`ifdef TAIL_LIGHT_MON_ERR_CODE_EN
  ,
  output logic [1:0]       err_code
`endif
);

  logic l_nxt, r_nxt, l_steady, r_steady;
  logic l_pat, l_trans, r_pat, r_trans;
  logic dual, pat_any, trans_any, violation;

  // Both sides would be sequencing at once: neither turn can be trusted.
  assign dual      = l_nxt && r_nxt;
  assign pat_any   = l_pat || r_pat;
  assign trans_any = l_trans || r_trans;
  assign violation = pat_any || trans_any || dual;
  assign brake_det = l_steady || r_steady;

  tail_light_side_decoder #(.CNT_W(CNT_W)) u_left (
    .clk            (clk),
    .rst            (rst),
    .lamp           (left_tail_light_controll),
    .seq_kill       (dual),
    .seq_active     (turn_left_det),
    .seq_active_nxt (l_nxt),
    .steady_on      (l_steady),
    .pat_err        (l_pat),
    .trans_err      (l_trans),
    .seq_cnt        (left_seq_cnt)
  );

  tail_light_side_decoder #(.CNT_W(CNT_W)) u_right (
    .clk            (clk),
    .rst            (rst),
    .lamp           (right_tail_light_controll),
    .seq_kill       (dual),
    .seq_active     (turn_right_det),
    .seq_active_nxt (r_nxt),
    .steady_on      (r_steady),
    .pat_err        (r_pat),
    .trans_err      (r_trans),
    .seq_cnt        (right_seq_cnt)
  );

  // A violation coinciding with err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else
      err <= violation || (err && !err_clr);
  end

`ifdef TAIL_LIGHT_MON_ERR_CODE_EN
  err_code_t code_r;
  err_code_t cause;

  always_comb begin
    cause = ERR_DUAL;
    if (pat_any)
      cause = ERR_PATTERN;
    else if (trans_any)
      cause = ERR_TRANS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      code_r <= ERR_NONE;
    else if (violation && (err_clr || !err))
      code_r <= cause;
    else if (err_clr)
      code_r <= ERR_NONE;
  end

  assign err_code = code_r;
`endif

endmodule

// File: tb/tb_tail_light_monitor.sv
// Directed bench for tail_light_monitor; err_code checks apply when TAIL_LIGHT_MON_ERR_CODE_EN is defined.
module tb_tail_light_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] left = 3'b000;
  logic [2:0] right = 3'b000;
  logic       err_clr = 1'b0;
  logic       brake_det, turn_left_det, turn_right_det, err;
  logic [7:0] left_seq_cnt, right_seq_cnt;
`ifdef TAIL_LIGHT_MON_ERR_CODE_EN
  logic [1:0] err_code;
`endif

  int n_chk = 0;
  int n_pass = 0;

  tail_light_monitor #(.CNT_W(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .left_tail_light_controll  (left),
    .right_tail_light_controll (right),
    .err_clr                   (err_clr),
    .brake_det                 (brake_det),
    .turn_left_det             (turn_left_det),
    .turn_right_det            (turn_right_det),
    .left_seq_cnt              (left_seq_cnt),
    .right_seq_cnt             (right_seq_cnt),
    .err                       (err)
`ifdef TAIL_LIGHT_MON_ERR_CODE_EN
    ,
    .err_code                  (err_code)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_code(input string tag, input int exp);
`ifdef TAIL_LIGHT_MON_ERR_CODE_EN
    chk(tag, int'(err_code), exp);
`endif
  endtask

  // Apply one sample pair, let the edge take it, settle just after the edge.
  task automatic cyc(input logic [2:0] l, input logic [2:0] r);
    left  = l;
    right = r;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_left();
    cyc(3'b001, 3'b000);
    cyc(3'b011, 3'b000);
    cyc(3'b111, 3'b000);
    cyc(3'b000, 3'b000);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(3'b000, 3'b000);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_brake", brake_det, 0);
    chk("rst_tl", turn_left_det, 0);
    chk("rst_tr", turn_right_det, 0);
    chk("rst_lcnt", left_seq_cnt, 0);
    chk("rst_rcnt", right_seq_cnt, 0);
    chk("rst_err", err, 0);
    chk_code("rst_code", 0);
    rst = 1'b0;
    cyc(3'b000, 3'b000);

    // left turn, three sweeps
    cyc(3'b001, 3'b000);
    chk("lt_before_011", turn_left_det, 0);
    cyc(3'b011, 3'b000);
    chk("lt_after_011", turn_left_det, 1);
    cyc(3'b111, 3'b000);
    cyc(3'b000, 3'b000);
    chk("lt_cnt1", left_seq_cnt, 1);
    sweep_left();
    chk("lt_gap_kept", turn_left_det, 1);
    sweep_left();
    chk("lt_cnt3", left_seq_cnt, 3);
    chk("lt_still_on", turn_left_det, 1);
    chk("lt_brake", brake_det, 0);
    chk("lt_err", err, 0);
    chk("lt_tr", turn_right_det, 0);
    cyc(3'b000, 3'b000);
    chk("lt_double_off", turn_left_det, 0);

    // brake on left, right turn sweep
    cyc(3'b111, 3'b001);
    chk("br_first_111", brake_det, 0);
    cyc(3'b111, 3'b011);
    chk("br_brake", brake_det, 1);
    chk("br_tr", turn_right_det, 1);
    chk("br_tl", turn_left_det, 0);
    cyc(3'b111, 3'b111);
    cyc(3'b111, 3'b000);
    chk("br_brake_hold", brake_det, 1);
    chk("br_rcnt", right_seq_cnt, 1);
    chk("br_err", err, 0);
    cyc(3'b000, 3'b000);
    chk("br_release", brake_det, 0);
    chk("br_tr_off", turn_right_det, 0);

    // illegal pattern, clear, clear colliding with a violation
    cyc(3'b101, 3'b000);
    chk("pat_err", err, 1);
    chk_code("pat_code", 1);
    cyc(3'b000, 3'b000);
    chk("pat_sticky", err, 1);
    clear_err();
    chk("pat_cleared", err, 0);
    chk_code("pat_code_clr", 0);
    err_clr = 1'b1;
    cyc(3'b110, 3'b000);
    err_clr = 1'b0;
    chk("clr_vs_viol", err, 1);
    chk_code("clr_vs_viol_code", 1);
    cyc(3'b000, 3'b000);
    clear_err();
    chk("clr2", err, 0);

    // illegal transition 111 -> 001
    cyc(3'b001, 3'b000);
    cyc(3'b111, 3'b000);
    chk("tr_001_111_ok", err, 0);
    cyc(3'b001, 3'b000);
    chk("tr_err", err, 1);
    chk_code("tr_code", 2);
    cyc(3'b000, 3'b000);
    clear_err();
    chk("tr_cleared", err, 0);

    // dual turn in phase
    cyc(3'b001, 3'b001);
    cyc(3'b011, 3'b011);
    chk("dual_err", err, 1);
    chk_code("dual_code", 3);
    chk("dual_tl", turn_left_det, 0);
    chk("dual_tr", turn_right_det, 0);
    cyc(3'b111, 3'b111);
    cyc(3'b000, 3'b000);
    chk("dual_tl_end", turn_left_det, 0);
    chk("dual_tr_end", turn_right_det, 0);
    clear_err();
    chk("dual_cleared", err, 0);

    // counter wrap from a fresh reset
    rst = 1'b1;
    cyc(3'b000, 3'b000);
    rst = 1'b0;
    chk("wrap_start", left_seq_cnt, 0);
    for (int i = 0; i < 255; i++) sweep_left();
    chk("wrap_255", left_seq_cnt, 255);
    sweep_left();
    chk("wrap_0", left_seq_cnt, 0);
    chk("wrap_err", err, 0);

    // asynchronous reset mid-sweep
    sweep_left();
    cyc(3'b001, 3'b000);
    cyc(3'b011, 3'b000);
    chk("mid_tl_pre", turn_left_det, 1);
    chk("mid_cnt_pre", left_seq_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_tl_async", turn_left_det, 0);
    chk("mid_cnt_async", left_seq_cnt, 0);
    cyc(3'b000, 3'b000);
    rst = 1'b0;
    cyc(3'b011, 3'b000);
    chk("mid_resume_err", err, 1);
    chk_code("mid_resume_code", 2);
    chk("mid_resume_tl", turn_left_det, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
